// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : FPU opcode enum and per-op decode helpers.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        FNEG      = 5'd0,
        FABS      = 5'd1,
        FADD      = 5'd2,
        FSUB      = 5'd3,
        FMUL      = 5'd4,
        FINV      = 5'd5,
        ITOF      = 5'd6,
        SQRT_INIT = 5'd7,
        FINV_INIT = 5'd8,
        FMV       = 5'd9,
        FORI      = 5'd10,
        SET       = 5'd11,
        FCLT      = 5'd12,
        FCEQ      = 5'd13,
        FCZ       = 5'd14,
        GET       = 5'd15,
        FTOI      = 5'd16,
        FOR       = 5'd17
    } fpu_op_e;

    function automatic logic is_wb32(input fpu_op_e op);
        return op inside {FNEG, FABS, FADD, FSUB, FMUL, FINV, ITOF, SQRT_INIT,
                          FINV_INIT, FMV, FORI, SET};
    endfunction

    function automatic logic is_cond(input fpu_op_e op);
        return op inside {FCLT, FCEQ, FCZ};
    endfunction

    function automatic logic uses_imm1(input fpu_op_e op);
        return op inside {ITOF, SET};
    endfunction

    function automatic logic uses_imm2(input fpu_op_e op);
        return op == FORI;
    endfunction

    function automatic logic uses_zero2(input fpu_op_e op);
        return op inside {FMV, SET, GET};
    endfunction

    // Register moves and immediates are all carried out as a bitwise OR.
    function automatic fpu_op_e exu_remap(input fpu_op_e op);
        return (op inside {FMV, FORI, SET, GET}) ? FOR : op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_core_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_core_ctl_if
// Brief    : Execute-stage request/response bundle for the FPU front end.
// Revision : 1.0
// ============================================================================
interface fpu_core_ctl_if
    import fpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CND_AW = 3
);
    logic              req_valid;
    logic              req_ready;
    fpu_op_e           req_op;
    logic [REG_AW-1:0] req_rs1;
    logic [REG_AW-1:0] req_rs2;
    logic [REG_AW-1:0] req_rd;
    logic [CND_AW-1:0] req_cd;
    logic [DATA_W-1:0] req_imm;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, req_cd, req_imm,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_cd, req_imm,
        output req_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : fpu_regfile
// Brief    : NREG x DATA_W register file, two async reads, one sync write.
// Revision : 1.0
// ============================================================================
module fpu_regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [REG_AW-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [REG_AW-1:0] i_raddr1,
    input  wire logic [REG_AW-1:0] i_raddr2,
    output logic      [DATA_W-1:0] o_rdata1,
    output logic      [DATA_W-1:0] o_rdata2
);
    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
endmodule
`default_nettype wire

// File: rtl/fpu_core_ctl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_core_ctl
// Brief    : FPU front end: regfile, operand select, issue FSM, writeback.
//            FPU_BYPASS_EN: accept in WB and forward the WB result.
// Revision : 1.0
// ============================================================================
module fpu_core_ctl
    import fpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    parameter  int NCOND  = 8,
    localparam int REG_AW = $clog2(NREG),
    localparam int CND_AW = $clog2(NCOND)
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    fpu_core_ctl_if.slave          bus,
    output logic      [NCOND-1:0]  cond,
    output logic                   exu_start,
    output logic      [OP_W-1:0]   exu_op,
    output logic      [DATA_W-1:0] exu_x1,
    output logic      [DATA_W-1:0] exu_x2,
    input  wire logic              exu_done,
    input  wire logic [DATA_W-1:0] exu_y32,
    input  wire logic              exu_y1
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_ready;
    logic              w_accept;
    logic              w_rsp_valid;
    logic              w_rf_we;
    logic              w_cond_we;
    logic              r_start;
    fpu_op_e           r_op;
    fpu_op_e           r_wb_op;
    logic [DATA_W-1:0] r_x1;
    logic [DATA_W-1:0] r_x2;
    logic [DATA_W-1:0] r_y32;
    logic              r_y1;
    logic [REG_AW-1:0] r_rd;
    logic [CND_AW-1:0] r_cd;
    logic [NCOND-1:0]  r_cond;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_x1;
    logic [DATA_W-1:0] w_x2;

    fpu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk      (clk),
        .i_we     (w_rf_we),
        .i_waddr  (r_rd),
        .i_wdata  (r_y32),
        .i_raddr1 (bus.req_rs1),
        .i_raddr2 (bus.req_rs2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

`ifdef FPU_BYPASS_EN
    assign w_ready = (r_state == S_IDLE) || (r_state == S_WB);
`else
    assign w_ready = (r_state == S_IDLE);
`endif
    assign w_accept = bus.req_valid & w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_valid = 1'b0;
        w_rf_we     = 1'b0;
        w_cond_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (exu_done) w_state_nxt = S_WB;
            end
            S_WB: begin
                w_rsp_valid = 1'b1;
                w_rf_we     = is_wb32(r_wb_op);
                w_cond_we   = is_cond(r_wb_op);
                w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A source naming the register being written this cycle sees the new value.
    always_comb begin
        w_src1 = w_rd1;
        w_src2 = w_rd2;
`ifdef FPU_BYPASS_EN
        if (w_rf_we && (bus.req_rs1 == r_rd)) w_src1 = r_y32;
        if (w_rf_we && (bus.req_rs2 == r_rd)) w_src2 = r_y32;
`endif
        w_x1 = uses_imm1(bus.req_op) ? bus.req_imm : w_src1;
        if (uses_imm2(bus.req_op)) begin
            w_x2 = bus.req_imm;
        end else if (uses_zero2(bus.req_op)) begin
            w_x2 = '0;
        end else begin
            w_x2 = w_src2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start <= 1'b0;
            r_op    <= FNEG;
            r_wb_op <= FNEG;
            r_x1    <= '0;
            r_x2    <= '0;
            r_rd    <= '0;
            r_cd    <= '0;
            r_y32   <= '0;
            r_y1    <= 1'b0;
            r_cond  <= '0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_op    <= exu_remap(bus.req_op);
                r_wb_op <= bus.req_op;
                r_x1    <= w_x1;
                r_x2    <= w_x2;
                r_rd    <= bus.req_rd;
                r_cd    <= bus.req_cd;
            end
            if ((r_state == S_EXEC) && exu_done) begin
                r_y32 <= exu_y32;
                r_y1  <= exu_y1;
            end
            if (w_cond_we) begin
                r_cond[r_cd] <= r_y1;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_y32;
    assign cond          = r_cond;
    assign exu_start     = r_start;
    assign exu_op        = r_op;
    assign exu_x1        = r_x1;
    assign exu_x2        = r_x2;
endmodule
`default_nettype wire
